// File: rtl/imem_fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package imem_fetch_pkg;

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_HOLD  = 3'd3,
        S_ERR   = 3'd4
    } state_e;

    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [2:0]  ARPROT_INSTR = 3'b100;
    localparam int unsigned PC_INCR      = 4;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// AXI4-Lite read-only channel between the fetch controller and instruction memory.
interface imem_fetch_ctrl_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned IMADDRLEN = 32
);
    logic                 im_arvalid;
    logic                 im_arready;
    logic [IMADDRLEN-1:0] im_araddr;
    logic [2:0]           im_arprot;
    logic                 im_rvalid;
    logic                 im_rready;
    logic [XLEN-1:0]      im_rdata;
    logic [1:0]           im_rresp;

    modport master (
        output im_arvalid, im_araddr, im_arprot, im_rready,
        input  im_arready, im_rvalid, im_rdata, im_rresp
    );

    modport slave (
        input  im_arvalid, im_araddr, im_arprot, im_rready,
        output im_arready, im_rvalid, im_rdata, im_rresp
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: one outstanding AXI4-Lite read, valid/ready to decode,
// redirects squash an in-flight fetch, read errors and misaligned targets are terminal.
module imem_fetch_ctrl
    import imem_fetch_pkg::*;
#(
    parameter int unsigned    XLEN      = 32,
    parameter int unsigned    IMADDRLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    imem_fetch_ctrl_if.master im,
    output logic            o_instr_valid,
    input  logic            i_instr_ready,
    output logic [XLEN-1:0] o_instr_data,
    output logic [XLEN-1:0] o_instr_pc,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_fetch_err,
    output state_e          o_state
);

    state_e          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pend_pc;
    logic            squash;
    logic            arvalid;
    logic            rready;
    logic            redir_bad;
    logic            r_err;
    logic            enter_err;

    assign im.im_arvalid = arvalid;
    assign im.im_araddr  = pc[IMADDRLEN-1:0];
    assign im.im_arprot  = ARPROT_INSTR;
    assign im.im_rready  = rready;
    assign o_state       = state;

    // Error sources; an R error outranks any redirect seen in the same cycle.
    assign redir_bad = i_redirect_valid && (i_redirect_pc[1:0] != 2'b00);
    assign r_err     = im.im_rvalid && (im.im_rresp != RESP_OKAY);
    assign enter_err = (state != S_ERR) && (((state == S_DATA) && r_err) || redir_bad);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_RESET;
            pc            <= RESET_PC;
            pend_pc       <= RESET_PC;
            squash        <= 1'b0;
            arvalid       <= 1'b0;
            rready        <= 1'b0;
            o_instr_valid <= 1'b0;
            o_instr_data  <= '0;
            o_instr_pc    <= RESET_PC;
            o_fetch_err   <= 1'b0;
        end else if (enter_err) begin
            state         <= S_ERR;
            o_fetch_err   <= 1'b1;
            arvalid       <= 1'b0;
            rready        <= 1'b0;
            o_instr_valid <= 1'b0;
        end else begin
            case (state)
                S_RESET: begin
                    if (i_redirect_valid) pc <= i_redirect_pc;
                    arvalid <= 1'b1;
                    state   <= S_ADDR;
                end
                S_ADDR: begin
                    // The AR cannot be withdrawn, so a redirect only marks its response for discard.
                    if (i_redirect_valid) begin
                        pend_pc <= i_redirect_pc;
                        squash  <= 1'b1;
                    end
                    if (im.im_arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (im.im_rvalid) begin
                        rready <= 1'b0;
                        if (squash || i_redirect_valid) begin
                            pc      <= i_redirect_valid ? i_redirect_pc : pend_pc;
                            squash  <= 1'b0;
                            arvalid <= 1'b1;
                            state   <= S_ADDR;
                        end else begin
                            o_instr_data  <= im.im_rdata;
                            o_instr_pc    <= pc;
                            o_instr_valid <= 1'b1;
                            state         <= S_HOLD;
                        end
                    end else if (i_redirect_valid) begin
                        pend_pc <= i_redirect_pc;
                        squash  <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (i_redirect_valid) begin
                        pc            <= i_redirect_pc;
                        o_instr_valid <= 1'b0;
                        arvalid       <= 1'b1;
                        state         <= S_ADDR;
                    end else if (i_instr_ready) begin
                        pc            <= pc + XLEN'(PC_INCR);
                        o_instr_valid <= 1'b0;
                        arvalid       <= 1'b1;
                        state         <= S_ADDR;
                    end
                end
                S_ERR: begin
                end
                default: state <= S_RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus random traffic against a
// program-order reference model and a bench-side memory slave.
module tb_imem_fetch_ctrl;
    import imem_fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid, instr_ready, redirect_valid, fetch_err;
    logic [31:0] instr_data, instr_pc, redirect_pc;
    state_e      state;

    always #5 clk = ~clk;

    imem_fetch_ctrl_if #(.XLEN(32), .IMADDRLEN(32)) im_bus ();

    imem_fetch_ctrl #(.XLEN(32), .IMADDRLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .im(im_bus),
        .o_instr_valid(instr_valid), .i_instr_ready(instr_ready),
        .o_instr_data(instr_data), .o_instr_pc(instr_pc),
        .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc),
        .o_fetch_err(fetch_err), .o_state(state)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    endtask

    // Memory contents: a nop at the first three words, a hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'd12) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // Memory slave state
    int          ar_wait = 0, r_wait = 0, ar_cnt = 0, r_cnt = 0;
    bit          r_pend = 0, r_bad = 0, rand_err = 0;
    logic [31:0] r_addr = '0, err_pc = 32'h1;
    logic [31:0] ar_log[$];

    // Reference model: the PC decode must see next, and whether fetch is dead.
    logic [31:0] m_pc = RESET_PC;
    bit          m_err = 0;
    int          idle = 0, cyc = 0;
    bit          prev_valid = 0;
    logic [31:0] present_pcs[$];
    int          present_cyc[$];

    task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy);
        bit ar_hs, r_hs, acc;
        @(negedge clk);
        im_bus.im_arready = im_bus.im_arvalid && (ar_cnt >= ar_wait);
        im_bus.im_rvalid  = r_pend && (r_cnt >= r_wait);
        im_bus.im_rdata   = r_pend ? mem_word(r_addr) : 32'hDEAD_BEEF;
        im_bus.im_rresp   = (r_pend && r_bad) ? 2'b10 : 2'b00;
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        ar_hs = im_bus.im_arvalid && im_bus.im_arready;
        r_hs  = im_bus.im_rvalid && im_bus.im_rready;
        acc   = instr_valid && rdy && !rv;
        if (!m_err) begin
            if (r_hs && r_bad)               m_err = 1;
            else if (rv && rpc[1:0] != 2'b00) m_err = 1;
            else if (rv)                     m_pc = rpc;
            else if (acc)                    m_pc = m_pc + 32'd4;
        end
        if (r_hs) r_pend = 0;
        else if (r_pend) r_cnt++;
        if (ar_hs) begin
            r_pend = 1;
            r_addr = im_bus.im_araddr;
            r_cnt  = 0;
            ar_cnt = 0;
            r_bad  = (im_bus.im_araddr == err_pc) || (rand_err && $urandom_range(0, 149) == 0);
            ar_log.push_back(im_bus.im_araddr);
        end else if (im_bus.im_arvalid) begin
            ar_cnt++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (m_err) begin
            check("err_flag", 32'(fetch_err), 32'd1);
            check("err_state", 32'(state), 32'(S_ERR));
            check("err_quiet", {30'b0, im_bus.im_arvalid, instr_valid}, 32'd0);
        end else begin
            check("no_err", 32'(fetch_err), 32'd0);
            check("ar_vs_instr", 32'(im_bus.im_arvalid & instr_valid), 32'd0);
            if (instr_valid) begin
                check("instr_pc", instr_pc, m_pc);
                check("instr_data", instr_data, mem_word(m_pc));
                idle = 0;
            end else begin
                idle++;
                if (idle > 40) begin
                    check("stall", 32'(idle), 32'd0);
                    idle = 0;
                end
            end
        end
        if (instr_valid && !prev_valid) begin
            present_pcs.push_back(instr_pc);
            present_cyc.push_back(cyc);
        end
        prev_valid = instr_valid;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        im_bus.im_arready = 0; im_bus.im_rvalid = 0;
        im_bus.im_rdata = '0;  im_bus.im_rresp = 2'b00;
        redirect_valid = 0; redirect_pc = '0; instr_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_arvalid", 32'(im_bus.im_arvalid), 32'd0);
        check("rst_rready", 32'(im_bus.im_rready), 32'd0);
        check("rst_ivalid", 32'(instr_valid), 32'd0);
        check("rst_idata", instr_data, 32'd0);
        check("rst_ipc", instr_pc, RESET_PC);
        check("rst_err", 32'(fetch_err), 32'd0);
        check("rst_state", 32'(state), 32'(S_RESET));
        check("arprot", 32'(im_bus.im_arprot), 32'd4);
        r_pend = 0; r_bad = 0; ar_cnt = 0; r_cnt = 0;
        m_pc = RESET_PC; m_err = 0; idle = 0; prev_valid = 0;
        ar_log.delete(); present_pcs.delete(); present_cyc.delete();
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t;
        int          err_age;

        // Straight-line fetch with zero-wait memory
        do_reset();
        step(0, '0, 1);
        check("sl_ar_first", 32'(im_bus.im_arvalid), 32'd1);
        check("sl_ar_addr0", im_bus.im_araddr, 32'h0);
        repeat (9) step(0, '0, 1);
        check("sl_count", 32'(present_pcs.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("sl_pc", (present_pcs.size() > i) ? present_pcs[i] : 32'hFFFF_FFFF, 32'(4 * i));
            check("sl_araddr", (ar_log.size() > i) ? ar_log[i] : 32'hFFFF_FFFF, 32'(4 * i));
        end
        check("sl_rate01", (present_cyc.size() > 1) ? 32'(present_cyc[1] - present_cyc[0]) : 32'd0, 32'd3);
        check("sl_rate12", (present_cyc.size() > 2) ? 32'(present_cyc[2] - present_cyc[1]) : 32'd0, 32'd3);

        // Backpressure in HOLD
        for (int i = 0; i < 10 && !instr_valid; i++) step(0, '0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, '0, 0);
            check("bp_valid", 32'(instr_valid), 32'd1);
            check("bp_no_ar", 32'(im_bus.im_arvalid), 32'd0);
            check("bp_pc", instr_pc, 32'd12);
            check("bp_data", instr_data, mem_word(32'd12));
        end
        step(0, '0, 1);
        check("bp_release", 32'(instr_valid), 32'd0);
        check("bp_next_ar", im_bus.im_araddr, 32'd16);

        // Redirect while the AR to 0x8 is stalled
        do_reset();
        ar_wait = 2;
        for (int i = 0; i < 40 && !(im_bus.im_arvalid && im_bus.im_araddr == 32'h8); i++) step(0, '0, 1);
        ar_log.delete(); present_pcs.delete();
        step(1, 32'h100, 1);
        check("rif_hold_addr", im_bus.im_araddr, 32'h8);
        step(0, '0, 1);
        check("rif_hold_addr2", im_bus.im_araddr, 32'h8);
        check("rif_hold_valid", 32'(im_bus.im_arvalid), 32'd1);
        for (int i = 0; i < 30 && present_pcs.size() == 0; i++) step(0, '0, 0);
        check("rif_ar0", (ar_log.size() > 0) ? ar_log[0] : 32'hFFFF_FFFF, 32'h8);
        check("rif_ar1", (ar_log.size() > 1) ? ar_log[1] : 32'hFFFF_FFFF, 32'h100);
        check("rif_pc", (present_pcs.size() > 0) ? present_pcs[0] : 32'hFFFF_FFFF, 32'h100);

        // Redirect in HOLD beats a simultaneous accept
        ar_wait = 0;
        step(1, 32'h40, 1);
        check("rh_valid", 32'(instr_valid), 32'd0);
        check("rh_arvalid", 32'(im_bus.im_arvalid), 32'd1);
        check("rh_araddr", im_bus.im_araddr, 32'h40);
        present_pcs.delete();
        for (int i = 0; i < 20 && present_pcs.size() == 0; i++) step(0, '0, 0);
        check("rh_pc", (present_pcs.size() > 0) ? present_pcs[0] : 32'hFFFF_FFFF, 32'h40);

        // Error response at 0xC is terminal until reset
        do_reset();
        err_pc = 32'hC;
        for (int i = 0; i < 30 && !fetch_err; i++) step(0, '0, 1);
        check("er_flag", 32'(fetch_err), 32'd1);
        check("er_state", 32'(state), 32'(S_ERR));
        repeat (5) step(0, '0, 1);
        check("er_last_ar", (ar_log.size() > 0) ? ar_log[ar_log.size() - 1] : 32'hFFFF_FFFF, 32'hC);
        err_pc = 32'h1;
        do_reset();
        for (int i = 0; i < 20 && present_pcs.size() == 0; i++) step(0, '0, 1);
        check("er_restart_pc", (present_pcs.size() > 0) ? present_pcs[0] : 32'hFFFF_FFFF, RESET_PC);

        // Misaligned redirect
        for (int i = 0; i < 20 && !instr_valid; i++) step(0, '0, 0);
        step(1, 32'h102, 0);
        check("mis_state", 32'(state), 32'(S_ERR));
        check("mis_flag", 32'(fetch_err), 32'd1);
        check("mis_arvalid", 32'(im_bus.im_arvalid), 32'd0);
        repeat (3) step(0, '0, 1);

        // Random traffic
        do_reset();
        rand_err = 1;
        err_age  = 0;
        for (int n = 0; n < 3000; n++) begin
            bit          rv;
            int          r;
            ar_wait = $urandom_range(0, 2);
            r_wait  = $urandom_range(0, 2);
            rv = !m_err && ($urandom_range(0, 19) == 0);
            r  = $urandom_range(0, 99);
            t  = $urandom;
            if (r == 0)      t[1:0] = 2'($urandom_range(1, 3));
            else if (r < 6)  t = 32'hFFFF_FFF8;
            else             t = {22'b0, t[9:2], 2'b00};
            step(rv, t, $urandom_range(0, 3) != 0);
            if (m_err) begin
                err_age++;
                if (err_age > 4) begin
                    do_reset();
                    err_age = 0;
                end
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
